// File: rtl/sensor_frame_st_tx.sv
// Purpose: capture framed sensor samples into a FIFO and replay each complete frame
//   as one fixed-length Avalon-ST packet with SOP/EOP framing.
// Latency: first SOP is driven 2 cycles after the edge that writes a frame's last word.
// Backpressure: readyLatency 0; data/SOP/EOP held while valid && !ready; frames that
//   do not fit in the FIFO are dropped at frame_start and never stall the stream.
// Ports: clk, rst (sync, active high); sample_data/sample_valid/frame_start capture
//   side; data_out_* stream source; pkt_cnt, drop_cnt, busy status.
// Optional: `define TX_TEST_PATTERN_EN adds input test_mode (self-generated packets).
module sensor_frame_st_tx #(
  parameter int DATA_W        = 32,
  parameter int WORDS_PER_PKT = 163,
  parameter int FIFO_DEPTH    = 512,
  parameter int ADDR_W        = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              sample_valid,
  input  logic              frame_start,
`ifdef TX_TEST_PATTERN_EN
  input  logic              test_mode,
`endif
  output logic [DATA_W-1:0] data_out_data,
  output logic              data_out_valid,
  input  logic              data_out_ready,
  output logic [1:0]        data_out_empty,
  output logic              data_out_startofpacket,
  output logic              data_out_endofpacket,
  output logic [15:0]       pkt_cnt,
  output logic [15:0]       drop_cnt,
  output logic              busy
);

  localparam int CNT_W = $clog2(WORDS_PER_PKT + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS_PER_PKT - 1);
  // A new frame fits only if the FIFO holds no more than this many words.
  localparam logic [ADDR_W:0] ADMIT_MAX = (ADDR_W + 1)'(FIFO_DEPTH - WORDS_PER_PKT);

  typedef enum logic {CAP_IDLE, CAP_RUN} cap_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_GAP} tx_state_t;

  cap_state_t        cap_state;
  tx_state_t         tx_state;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [ADDR_W:0]   wr_ptr, rd_ptr, used, committed;
  logic [CNT_W-1:0]  wr_ctr, rd_ctr;
  logic              commit_pend;
  logic              tx_test;
  logic              tm, s_vld, s_fs, admit, wr_en, xfer, last_xfer, fifo_dec;
  logic [31:0]       pattern;

`ifdef TX_TEST_PATTERN_EN
  assign tm = test_mode;
`else
  assign tm = 1'b0;
`endif

  // Test mode blinds the capture path entirely.
  assign s_vld = sample_valid & ~tm;
  assign s_fs  = frame_start & ~tm;

  // Admission is only decided in CAP_IDLE, where no words are reserved, so the
  // occupied count alone is the reservation-aware free-space test.
  assign used  = wr_ptr - rd_ptr;
  assign admit = (cap_state == CAP_IDLE) && s_fs && (used <= ADMIT_MAX);
  assign wr_en = s_vld && ((cap_state == CAP_RUN) || admit);

  assign xfer      = data_out_valid && data_out_ready;
  assign last_xfer = xfer && (rd_ctr == LAST_IDX);
  assign fifo_dec  = last_xfer && !tx_test;

  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_ptr[ADDR_W-1:0]] <= sample_data;
  end

  // Capture FSM. The commit is staged through commit_pend so the transmitter
  // sees a frame one cycle after its last word lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_state   <= CAP_IDLE;
      wr_ctr      <= '0;
      wr_ptr      <= '0;
      commit_pend <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      commit_pend <= 1'b0;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (cap_state == CAP_IDLE) begin
        if (s_fs) begin
          if (admit) begin
            cap_state <= CAP_RUN;
            wr_ctr    <= CNT_W'(s_vld);   // sample on the frame_start cycle is word 0
          end else if (drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
          end
        end
      end else if (s_vld) begin
        if (wr_ctr == LAST_IDX) begin
          cap_state   <= CAP_IDLE;
          wr_ctr      <= '0;
          commit_pend <= 1'b1;
        end else begin
          wr_ctr <= wr_ctr + 1'b1;
        end
      end
    end
  end

  // Transmit FSM. tx_test latches the packet source at TX_IDLE so a test_mode
  // change never splits a packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state  <= TX_IDLE;
      rd_ctr    <= '0;
      rd_ptr    <= '0;
      committed <= '0;
      pkt_cnt   <= '0;
      tx_test   <= 1'b0;
    end else begin
      committed <= committed + {{ADDR_W{1'b0}}, commit_pend} - {{ADDR_W{1'b0}}, fifo_dec};
      if (xfer && !tx_test) rd_ptr <= rd_ptr + 1'b1;
      case (tx_state)
        TX_IDLE: begin
          rd_ctr <= '0;
          if (tm) begin
            tx_test  <= 1'b1;
            tx_state <= TX_SEND;
          end else if (committed != '0) begin
            tx_test  <= 1'b0;
            tx_state <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (xfer) begin
            if (rd_ctr == LAST_IDX) begin
              pkt_cnt  <= pkt_cnt + 16'd1;
              tx_state <= TX_GAP;
            end else begin
              rd_ctr <= rd_ctr + 1'b1;
            end
          end
        end
        TX_GAP:  tx_state <= TX_IDLE;
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  assign pattern = {pkt_cnt, 16'(rd_ctr)};

  always_comb begin
    data_out_data = '0;
    if (tx_state == TX_SEND) begin
      data_out_data = tx_test ? DATA_W'(pattern) : mem[rd_ptr[ADDR_W-1:0]];
    end
  end

  assign data_out_valid         = (tx_state == TX_SEND);
  assign data_out_startofpacket = (tx_state == TX_SEND) && (rd_ctr == '0);
  assign data_out_endofpacket   = (tx_state == TX_SEND) && (rd_ctr == LAST_IDX);
  assign data_out_empty         = 2'b00;
  assign busy = (cap_state == CAP_RUN) || commit_pend || (committed != '0);

endmodule

// File: tb/tb_sensor_frame_st_tx.sv
module tb_sensor_frame_st_tx;
  localparam int WPP = 163;

  typedef struct packed {
    logic [31:0] d;
    logic        sop;
    logic        eop;
  } exp_t;

  typedef struct {
    logic [31:0] base;
    int          rmode;
    int          exp_pkt;
    int          exp_drop;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] sample_data = '0;
  logic        sample_valid = 1'b0;
  logic        frame_start = 1'b0;
  logic        data_out_ready = 1'b1;
  logic [31:0] data_out_data;
  logic        data_out_valid;
  logic [1:0]  data_out_empty;
  logic        data_out_startofpacket;
  logic        data_out_endofpacket;
  logic [15:0] pkt_cnt;
  logic [15:0] drop_cnt;
  logic        busy;
`ifdef TX_TEST_PATTERN_EN
  logic        test_mode = 1'b0;
`endif

  int   total = 0;
  int   bad = 0;
  int   xfers = 0;
  int   ready_mode = 0;
  exp_t exp_q[$];

  sensor_frame_st_tx #(
    .DATA_W(32), .WORDS_PER_PKT(WPP), .FIFO_DEPTH(512), .ADDR_W(9)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sample_data(sample_data),
    .sample_valid(sample_valid),
    .frame_start(frame_start),
`ifdef TX_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .data_out_data(data_out_data),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .data_out_empty(data_out_empty),
    .data_out_startofpacket(data_out_startofpacket),
    .data_out_endofpacket(data_out_endofpacket),
    .pkt_cnt(pkt_cnt),
    .drop_cnt(drop_cnt),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Ready driver: 0 = always ready, 1 = toggle every cycle, other = held low.
  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0:       data_out_ready = 1'b1;
      1:       data_out_ready = ~data_out_ready;
      default: data_out_ready = 1'b0;
    endcase
  end

  // Stream monitor: scoreboard compare, stall stability, inter-packet gap.
  initial begin
    logic        prev_stall = 1'b0;
    logic [31:0] prev_d = '0;
    logic        prev_sop = 1'b0, prev_eop = 1'b0;
    int          gap_cnt = 0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        gap_cnt = 0;
      end else begin
        if (prev_stall)
          check("stall_hold", {data_out_valid, data_out_data, data_out_startofpacket, data_out_endofpacket},
                {1'b1, prev_d, prev_sop, prev_eop});
        if (gap_cnt > 0) begin
          check("post_eop_idle", data_out_valid, 1'b0);
          gap_cnt--;
        end
        if (data_out_valid && data_out_ready) begin
          xfers++;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_word got=%h expected=none", data_out_data);
          end else begin
            e = exp_q.pop_front();
            check("word", {data_out_data, data_out_startofpacket, data_out_endofpacket}, e);
          end
          if (data_out_endofpacket) gap_cnt = 2;
        end
        prev_stall = data_out_valid && !data_out_ready;
        prev_d     = data_out_data;
        prev_sop   = data_out_startofpacket;
        prev_eop   = data_out_endofpacket;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Drives one frame back to back; restart_k pulses a spurious frame_start mid-frame.
  task automatic send_frame(input logic [31:0] base, input bit admit, input int restart_k);
    for (int k = 0; k < WPP; k++) begin
      @(posedge clk); #1;
      frame_start  = (k == 0) || (k == restart_k);
      sample_valid = 1'b1;
      sample_data  = base + 32'(k);
      if (admit) exp_q.push_back('{base + 32'(k), k == 0, k == WPP - 1});
    end
  endtask

  task automatic end_frame();
    @(posedge clk); #1;
    frame_start  = 1'b0;
    sample_valid = 1'b0;
  endtask

  task automatic wait_pkts(input int target, input string name);
    int n = 0;
    while (pkt_cnt != 16'(target) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, pkt_cnt, 64'(target));
  endtask

  initial begin
    vec_t vecs[3];
    int   x0;
    int   n;
    vecs[0] = '{32'h0000_00F0, 1, 2, 0};
    vecs[1] = '{32'h0000_1000, 0, 3, 0};
    vecs[2] = '{32'hABCD_0000, 1, 4, 0};

    // Reset state
    tick(3);
    check("rst_valid", data_out_valid, 0);
    check("rst_sop_eop", {data_out_startofpacket, data_out_endofpacket}, 0);
    check("rst_data", data_out_data, 0);
    check("rst_counts", {pkt_cnt, drop_cnt}, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick(2);
    check("idle_valid", data_out_valid, 0);
    check("idle_empty", data_out_empty, 0);

    // First frame, ready=1, with SOP latency
    x0 = xfers;
    send_frame(32'hF0, 1, -1);
    end_frame();                       // this edge writes the last word
    check("busy_after_capture", busy, 1);
    tick(1);
    check("lat_cycle1_valid", data_out_valid, 0);
    tick(1);
    check("lat_cycle2_sop", {data_out_valid, data_out_startofpacket, data_out_data}, {2'b11, 32'hF0});
    wait_pkts(1, "pkt1_cnt");
    check("pkt1_xfers", 64'(xfers - x0), 64'(WPP));
    check("pkt1_empty", data_out_empty, 0);
    tick(3);

    // Table-driven frames with different ready patterns
    for (int i = 0; i < 3; i++) begin
      ready_mode = vecs[i].rmode;
      x0 = xfers;
      send_frame(vecs[i].base, 1, -1);
      end_frame();
      wait_pkts(vecs[i].exp_pkt, "vec_pkt_cnt");
      check("vec_drop_cnt", drop_cnt, 64'(vecs[i].exp_drop));
      check("vec_xfers", 64'(xfers - x0), 64'(WPP));
      tick(3);
      check("vec_sb_drained", 64'(exp_q.size()), 0);
      check("vec_busy_clear", busy, 0);
    end

    // Four back-to-back frames with the sink stalled: fourth does not fit
    ready_mode = 2;
    tick(2);
    x0 = xfers;
    send_frame(32'h0001_0000, 1, -1);
    send_frame(32'h0002_0000, 1, -1);
    send_frame(32'h0003_0000, 1, -1);
    send_frame(32'h0004_0000, 0, -1);
    end_frame();
    tick(4);
    check("b2b_drop_cnt", drop_cnt, 1);
    check("b2b_busy", busy, 1);
    check("b2b_stalled_sop", {data_out_valid, data_out_startofpacket, data_out_data}, {2'b11, 32'h0001_0000});
    ready_mode = 0;
    wait_pkts(7, "b2b_pkt_cnt");
    tick(3);
    check("b2b_xfers", 64'(xfers - x0), 64'(3 * WPP));
    check("b2b_sb_drained", 64'(exp_q.size()), 0);

    // Stray samples in CAP_IDLE and a frame_start mid-capture
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      sample_valid = 1'b1;
      sample_data  = 32'hDEAD_0000 + 32'(k);
    end
    x0 = xfers;
    send_frame(32'h0000_5000, 1, 50);
    @(posedge clk); #1;
    frame_start = 1'b0;
    sample_data = 32'hDEAD_BEEF;     // stray sample right after the frame
    end_frame();
    wait_pkts(8, "stray_pkt_cnt");
    tick(10);
    check("stray_drop_cnt", drop_cnt, 1);
    check("stray_xfers", 64'(xfers - x0), 64'(WPP));
    check("stray_no_extra", data_out_valid, 0);

    // Reset in the middle of a packet
    x0 = xfers;
    send_frame(32'h0000_7000, 1, -1);
    end_frame();
    n = 0;
    while ((xfers - x0) < 80 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("mid_reset_reached", 64'((xfers - x0) >= 80), 1);
    rst = 1'b1;
    exp_q.delete();
    tick(1);
    check("mid_reset_valid", {data_out_valid, data_out_startofpacket, data_out_endofpacket}, 0);
    check("mid_reset_counts", {pkt_cnt, drop_cnt}, 0);
    check("mid_reset_busy", busy, 0);
    rst = 1'b0;
    tick(2);
    x0 = xfers;
    send_frame(32'h0000_9000, 1, -1);
    end_frame();
    wait_pkts(1, "post_reset_pkt_cnt");
    tick(3);
    check("post_reset_xfers", 64'(xfers - x0), 64'(WPP));
    check("post_reset_sb", 64'(exp_q.size()), 0);

`ifdef TX_TEST_PATTERN_EN
    // Self-generated packets: two packets, then test_mode dropped in the gap
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < WPP; k++)
        exp_q.push_back('{{16'(1 + p), 16'(k)}, k == 0, k == WPP - 1});
    test_mode = 1'b1;
    wait_pkts(3, "tp_pkt_cnt");
    test_mode = 1'b0;
    tick(10);
    check("tp_sb_drained", 64'(exp_q.size()), 0);
    check("tp_stopped", data_out_valid, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
